eth_rx_hdr_arb: RTL and testbench

- Round-robin scheduler that shares one header-parse pipeline between NPORTS RX MAC channels.
- Each channel is an eth_rxmac_top + header_buffer pair presenting a captured header (data, length, error flag) with a valid/ready handshake.
- Grants one whole header at a time, registers it onto a single output port with the source port index, and silently pops (drops) errored or out-of-range headers.
- Sits between the per-port header buffers and the downstream parser; all in the MRxClk domain.

---
 rtl/eth_rx_pkg.sv | 20 ++
 rtl/eth_rr_arbiter.sv | 39 +++
 rtl/eth_rx_hdr_arb.sv | 143 ++++++++++++++
 tb/tb_eth_rx_hdr_arb.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_rx_pkg.sv
// ---------------------------------------------------------------------------
// eth_rx_pkg
// Shared types and constants for the RX header arbitration path.
//   state_t     : arbiter FSM states (IDLE, SEND)
//   LEN_W       : width of a header length field
//   DEF_HDR_W   : default header bus width (192 bytes)
//   DEF_MAX_LEN : default largest accepted header length
// ---------------------------------------------------------------------------
package eth_rx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int LEN_W       = 16;
  localparam int DEF_HDR_W   = 1536;
  localparam int DEF_MAX_LEN = 1518;

endpackage

// File: rtl/eth_rr_arbiter.sv
// ---------------------------------------------------------------------------
// eth_rr_arbiter
// Purely combinational rotating-priority encoder. The search starts at the
// port after the last grant (lp+1) and wraps modulo NPORTS; the first
// requesting port wins.
// Ports:
//   req        in  NPORTS  request vector
//   lp         in  PW      index of the last granted port
//   grantValid out 1       some port is requesting
//   grantIdx   out PW      winning port index (0 when grantValid=0)
// ---------------------------------------------------------------------------
module eth_rr_arbiter #(
  parameter int NPORTS = 4,
  parameter int PW     = $clog2(NPORTS)
) (
  input  logic [NPORTS-1:0] req,
  input  logic [PW-1:0]     lp,
  output logic              grantValid,
  output logic [PW-1:0]     grantIdx
);

  logic [PW-1:0] cand;

  // Walk from the farthest candidate to the nearest one so that the
  // nearest requester after lp is the last (and therefore final) assignment.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    cand       = '0;
    for (int k = NPORTS; k >= 1; k--) begin
      cand = PW'((int'(lp) + k) % NPORTS);
      if (req[cand]) begin
        grantValid = 1'b1;
        grantIdx   = cand;
      end
    end
  end

endmodule

// File: rtl/eth_rx_hdr_arb.sv
// ---------------------------------------------------------------------------
// eth_rx_hdr_arb
// Round-robin scheduler sharing one header-parse pipeline between NPORTS RX
// MAC channels. One whole header is granted at a time and registered onto a
// single output with its source port; errored, empty or oversize headers are
// popped and counted without being forwarded. MRxClk domain only.
// Ports:
//   MRxClk     in  1             clock
//   Reset      in  1             asynchronous active-low reset
//   Enable     in  1             allow new grants (current transfer always completes)
//   req_valid  in  NPORTS        per-port header valid
//   req_error  in  NPORTS        per-port frame error, qualified by req_valid
//   req_len    in  NPORTS*16     per-port header length, port i at [16i +: 16]
//   req_data   in  NPORTS*HDR_W  per-port header, port i at [HDR_W*i +: HDR_W]
//   req_ready  out NPORTS        per-port pop strobe, at most one bit high
//   out_valid  out 1             output header valid
//   out_ready  in  1             downstream accepts
//   out_data   out HDR_W         registered header
//   out_len    out 16            registered length
//   out_port   out PW            source port of out_data
//   drop_cnt   out 16            saturating count of dropped headers
//   busy       out 1             high while a header is being offered
// ---------------------------------------------------------------------------
module eth_rx_hdr_arb
  import eth_rx_pkg::*;
#(
  parameter int NPORTS  = 4,
  parameter int PW      = $clog2(NPORTS),
  parameter int HDR_W   = DEF_HDR_W,
  parameter int MAX_LEN = DEF_MAX_LEN
) (
  input  logic                    MRxClk,
  input  logic                    Reset,
  input  logic                    Enable,
  input  logic [NPORTS-1:0]       req_valid,
  input  logic [NPORTS-1:0]       req_error,
  input  logic [NPORTS*LEN_W-1:0] req_len,
  input  logic [NPORTS*HDR_W-1:0] req_data,
  output logic [NPORTS-1:0]       req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [HDR_W-1:0]        out_data,
  output logic [LEN_W-1:0]        out_len,
  output logic [PW-1:0]           out_port,
  output logic [15:0]             drop_cnt,
  output logic                    busy
);

  state_t            state;
  state_t            nextState;
  logic [PW-1:0]     lp;
  logic              grantValid;
  logic [PW-1:0]     grantIdx;
  logic              grantErr;
  logic [LEN_W-1:0]  grantLen;
  logic [HDR_W-1:0]  grantData;
  logic              lenBad;
  logic              doDrop;
  logic              doLoad;

  function automatic logic [15:0] satInc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  eth_rr_arbiter #(
    .NPORTS (NPORTS),
    .PW     (PW)
  ) uArb (
    .req        (req_valid),
    .lp         (lp),
    .grantValid (grantValid),
    .grantIdx   (grantIdx)
  );

  // Steer the winning port's header onto a single bus.
  always_comb begin
    grantLen  = '0;
    grantData = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (grantIdx == PW'(i)) begin
        grantLen  = req_len[i*LEN_W +: LEN_W];
        grantData = req_data[i*HDR_W +: HDR_W];
      end
    end
  end

  assign grantErr = req_error[grantIdx];
  assign lenBad   = (grantLen == '0) || (grantLen > LEN_W'(MAX_LEN));

  always_comb begin
    nextState = state;
    req_ready = '0;
    doDrop    = 1'b0;
    doLoad    = 1'b0;
    case (state)
      IDLE: begin
        if (Enable && grantValid) begin
          req_ready[grantIdx] = 1'b1;
          if (grantErr || lenBad) begin
            doDrop = 1'b1;
          end else begin
            doLoad    = 1'b1;
            nextState = SEND;
          end
        end
      end
      SEND: begin
        // The handshake cycle never grants, so the minimum spacing is two cycles.
        if (out_valid && out_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Grant stage -> registered output stage
  always_ff @(posedge MRxClk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      lp        <= PW'(NPORTS - 1);
      out_valid <= 1'b0;
      out_data  <= '0;
      out_len   <= '0;
      out_port  <= '0;
      drop_cnt  <= '0;
    end else begin
      state <= nextState;
      // Drops count as a turn, so the pointer moves on either outcome.
      if (doDrop || doLoad) lp <= grantIdx;
      if (doDrop) drop_cnt <= satInc(drop_cnt);
      if (doLoad) begin
        out_valid <= 1'b1;
        out_data  <= grantData;
        out_len   <= grantLen;
        out_port  <= grantIdx;
      end else if (state == SEND && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = (state == SEND);

endmodule

// File: tb/tb_eth_rx_hdr_arb.sv
// ---------------------------------------------------------------------------
// tb_eth_rx_hdr_arb
// Self-checking bench for eth_rx_hdr_arb: directed scenarios plus a
// randomized run compared against a behavioural model of the scheduler.
// ---------------------------------------------------------------------------
module tb_eth_rx_hdr_arb;

  localparam int NPORTS  = 4;
  localparam int PW      = 2;
  localparam int HDR_W   = 1536;
  localparam int MAX_LEN = 1518;

  logic                    MRxClk = 1'b0;
  logic                    Reset;
  logic                    Enable;
  logic [NPORTS-1:0]       req_valid;
  logic [NPORTS-1:0]       req_error;
  logic [NPORTS*16-1:0]    req_len;
  logic [NPORTS*HDR_W-1:0] req_data;
  logic [NPORTS-1:0]       req_ready;
  logic                    out_valid;
  logic                    out_ready;
  logic [HDR_W-1:0]        out_data;
  logic [15:0]             out_len;
  logic [PW-1:0]           out_port;
  logic [15:0]             drop_cnt;
  logic                    busy;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  bit               mSend;
  int               mLp;
  int               mDrop;
  logic [HDR_W-1:0] mData;
  logic [15:0]      mLen;
  int               mPort;

  always #5 MRxClk = ~MRxClk;

  eth_rx_hdr_arb #(
    .NPORTS  (NPORTS),
    .PW      (PW),
    .HDR_W   (HDR_W),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .MRxClk    (MRxClk),
    .Reset     (Reset),
    .Enable    (Enable),
    .req_valid (req_valid),
    .req_error (req_error),
    .req_len   (req_len),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_len   (out_len),
    .out_port  (out_port),
    .drop_cnt  (drop_cnt),
    .busy      (busy)
  );

  function automatic logic [HDR_W-1:0] randHdr();
    logic [HDR_W-1:0] h;
    for (int i = 0; i < HDR_W/32; i++) h[i*32 +: 32] = $urandom;
    return h;
  endfunction

  function automatic logic [15:0] randLen();
    case ($urandom_range(0, 9))
      0:       return 16'd0;
      1:       return 16'(MAX_LEN);
      2:       return 16'(MAX_LEN + 1);
      3:       return 16'hFFFF;
      default: return 16'($urandom_range(1, MAX_LEN));
    endcase
  endfunction

  task automatic setPort(input int p, input logic v, input logic e,
                         input logic [15:0] len, input logic [HDR_W-1:0] d);
    req_valid[p]              = v;
    req_error[p]              = e;
    req_len[p*16 +: 16]       = len;
    req_data[p*HDR_W +: HDR_W] = d;
  endtask

  function automatic logic [NPORTS-1:0] oneHot(input int p);
    logic [NPORTS-1:0] r;
    r = '0;
    r[p] = 1'b1;
    return r;
  endfunction

  // Next requester after the last served one, wrapping around the ports.
  function automatic int mWinner();
    for (int k = 1; k <= NPORTS; k++) begin
      if (req_valid[(mLp + k) % NPORTS]) return (mLp + k) % NPORTS;
    end
    return -1;
  endfunction

  function automatic bit mBad(input int p);
    return req_error[p] || (req_len[p*16 +: 16] == 16'd0) ||
           (int'(req_len[p*16 +: 16]) > MAX_LEN);
  endfunction

  function automatic logic [NPORTS-1:0] mReady();
    int w;
    w = mWinner();
    if (!mSend && Enable === 1'b1 && w >= 0) return oneHot(w);
    return '0;
  endfunction

  task automatic mReset();
    mSend = 0;
    mLp   = NPORTS - 1;
    mDrop = 0;
    mData = '0;
    mLen  = '0;
    mPort = 0;
  endtask

  // Advance the model with the inputs present now, then cross one clock edge.
  task automatic tick();
    int w;
    if (mSend) begin
      if (out_ready) mSend = 0;
    end else if (Enable) begin
      w = mWinner();
      if (w >= 0) begin
        mLp = w;
        if (mBad(w)) begin
          if (mDrop < 65535) mDrop++;
        end else begin
          mSend = 1;
          mData = req_data[w*HDR_W +: HDR_W];
          mLen  = req_len[w*16 +: 16];
          mPort = w;
        end
      end
    end
    @(posedge MRxClk);
    #1;
  endtask

  task automatic clearInputs();
    req_valid = '0;
    req_error = '0;
    req_len   = '0;
    req_data  = '0;
    Enable    = 1'b1;
    out_ready = 1'b1;
  endtask

  task automatic resetDut();
    Reset = 1'b0;
    clearInputs();
    #2;
    mReset();
    @(negedge MRxClk);
    Reset = 1'b1;
    @(posedge MRxClk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    clearInputs();
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_out_data: got nonzero want 0"); end
    checks++; if (out_len !== 16'd0) begin errors++; $display("FAIL rst_out_len: got %0d want 0", out_len); end
    checks++; if (out_port !== 2'd0) begin errors++; $display("FAIL rst_out_port: got %0d want 0", out_port); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL rst_drop_cnt: got %0d want 0", drop_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    mReset();
    @(negedge MRxClk);
    Reset = 1'b1;
    @(posedge MRxClk);
    #1;
  endtask

  task automatic test_single();
    logic [HDR_W-1:0] d;
    resetDut();
    d = randHdr();
    setPort(2, 1'b1, 1'b0, 16'd64, d);
    @(negedge MRxClk);
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    tick();
    req_valid[2] = 1'b0;
    @(negedge MRxClk);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready2: got %b want 0000", req_ready); end
    checks++; if (out_valid !== 1'b1 || out_port !== 2'd2 || out_len !== 16'd64)
      begin errors++; $display("FAIL single_out: got v=%b port=%0d len=%0d want v=1 port=2 len=64", out_valid, out_port, out_len); end
    checks++; if (out_data !== d) begin errors++; $display("FAIL single_data: got %h want %h", out_data[63:0], d[63:0]); end
    checks++; if (drop_cnt !== 16'd0 || busy !== 1'b1) begin errors++; $display("FAIL single_cnt: got drop=%0d busy=%b want 0,1", drop_cnt, busy); end
    tick();
  endtask

  task automatic test_all_ports();
    resetDut();
    for (int p = 0; p < NPORTS; p++) setPort(p, 1'b1, 1'b0, 16'(100 + p), randHdr());
    for (int k = 0; k < 6; k++) begin
      @(negedge MRxClk);
      checks++; if (req_ready !== oneHot(k % NPORTS) || out_valid !== 1'b0)
        begin errors++; $display("FAIL rr_grant%0d: got ready=%b v=%b want ready=%b v=0", k, req_ready, out_valid, oneHot(k % NPORTS)); end
      tick();
      @(negedge MRxClk);
      checks++; if (out_valid !== 1'b1 || out_port !== PW'(k % NPORTS) || req_ready !== 4'b0000)
        begin errors++; $display("FAIL rr_out%0d: got v=%b port=%0d ready=%b want v=1 port=%0d ready=0000", k, out_valid, out_port, req_ready, k % NPORTS); end
      checks++; if (out_data !== req_data[(k % NPORTS)*HDR_W +: HDR_W] || out_len !== 16'(100 + k % NPORTS))
        begin errors++; $display("FAIL rr_data%0d: got len=%0d want %0d", k, out_len, 100 + k % NPORTS); end
      tick();
    end
  endtask

  task automatic test_drops();
    logic [HDR_W-1:0] d0;
    resetDut();
    setPort(1, 1'b1, 1'b1, 16'd64, randHdr());
    setPort(3, 1'b1, 1'b0, 16'(MAX_LEN + 1), randHdr());
    @(negedge MRxClk);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL drop_err_ready: got %b want 0010", req_ready); end
    tick();
    req_valid[1] = 1'b0;
    @(negedge MRxClk);
    checks++; if (req_ready !== 4'b1000 || out_valid !== 1'b0)
      begin errors++; $display("FAIL drop_len_ready: got ready=%b v=%b want 1000,0", req_ready, out_valid); end
    tick();
    req_valid[3] = 1'b0;
    @(negedge MRxClk);
    checks++; if (drop_cnt !== 16'd2 || out_valid !== 1'b0)
      begin errors++; $display("FAIL drop_cnt2: got cnt=%0d v=%b want 2,0", drop_cnt, out_valid); end
    d0 = randHdr();
    setPort(0, 1'b1, 1'b0, 16'(MAX_LEN), d0);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL max_len_ready: got %b want 0001", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    @(negedge MRxClk);
    checks++; if (out_valid !== 1'b1 || out_port !== 2'd0 || out_len !== 16'(MAX_LEN) || out_data !== d0 || drop_cnt !== 16'd2)
      begin errors++; $display("FAIL max_len_out: got v=%b port=%0d len=%0d cnt=%0d want 1,0,%0d,2", out_valid, out_port, out_len, drop_cnt, MAX_LEN); end
    tick();
  endtask

  task automatic test_stall();
    logic [HDR_W-1:0] d1;
    int bad;
    resetDut();
    d1 = randHdr();
    setPort(1, 1'b1, 1'b0, 16'd200, d1);
    out_ready = 1'b0;
    @(negedge MRxClk);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL stall_grant: got %b want 0010", req_ready); end
    tick();
    req_valid[1] = 1'b0;
    setPort(0, 1'b1, 1'b0, 16'd50, randHdr());
    setPort(2, 1'b1, 1'b0, 16'd60, randHdr());
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge MRxClk);
      if (out_valid !== 1'b1 || out_data !== d1 || out_len !== 16'd200 || out_port !== 2'd1 ||
          req_ready !== 4'b0000 || busy !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold%0d: got v=%b len=%0d port=%0d ready=%b want 1,200,1,0000", c, out_valid, out_len, out_port, req_ready);
      end
      tick();
    end
    checks++; if (bad != 0) errors++;
    out_ready = 1'b1;
    @(negedge MRxClk);
    checks++; if (out_valid !== 1'b1 || req_ready !== 4'b0000)
      begin errors++; $display("FAIL stall_hs: got v=%b ready=%b want 1,0000", out_valid, req_ready); end
    tick();
    @(negedge MRxClk);
    checks++; if (out_valid !== 1'b0 || req_ready !== 4'b0100)
      begin errors++; $display("FAIL stall_next: got v=%b ready=%b want 0,0100", out_valid, req_ready); end
    tick();
  endtask

  task automatic test_enable();
    resetDut();
    Enable = 1'b0;
    for (int p = 0; p < NPORTS; p++) setPort(p, 1'b1, 1'b0, 16'd80, randHdr());
    for (int c = 0; c < 5; c++) begin
      @(negedge MRxClk);
      checks++; if (req_ready !== 4'b0000 || out_valid !== 1'b0)
        begin errors++; $display("FAIL en_off%0d: got ready=%b v=%b want 0000,0", c, req_ready, out_valid); end
      tick();
    end
    Enable = 1'b1;
    @(negedge MRxClk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL en_on: got %b want 0001", req_ready); end
    tick();
    Enable    = 1'b0;
    out_ready = 1'b0;
    req_valid[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge MRxClk);
      checks++; if (out_valid !== 1'b1 || out_port !== 2'd0)
        begin errors++; $display("FAIL en_fall%0d: got v=%b port=%0d want 1,0", c, out_valid, out_port); end
      tick();
    end
    out_ready = 1'b1;
    @(negedge MRxClk);
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge MRxClk);
      checks++; if (req_ready !== 4'b0000 || out_valid !== 1'b0)
        begin errors++; $display("FAIL en_after%0d: got ready=%b v=%b want 0000,0", c, req_ready, out_valid); end
      tick();
    end
  endtask

  task automatic test_reset_midsend();
    resetDut();
    setPort(2, 1'b1, 1'b0, 16'd300, randHdr());
    out_ready = 1'b0;
    @(negedge MRxClk);
    tick();
    req_valid[2] = 1'b0;
    @(negedge MRxClk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_loaded: got v=%b want 1", out_valid); end
    #2;
    Reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_len !== 16'd0 || out_port !== 2'd0 || busy !== 1'b0)
      begin errors++; $display("FAIL mid_async: got v=%b len=%0d port=%0d busy=%b want all 0", out_valid, out_len, out_port, busy); end
    mReset();
    out_ready = 1'b1;
    for (int p = 0; p < NPORTS; p++) setPort(p, 1'b1, 1'b0, 16'd90, randHdr());
    @(negedge MRxClk);
    Reset = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001 || drop_cnt !== 16'd0)
      begin errors++; $display("FAIL mid_first: got ready=%b cnt=%0d want 0001,0", req_ready, drop_cnt); end
    tick();
    @(negedge MRxClk);
    checks++; if (out_valid !== 1'b1 || out_port !== 2'd0)
      begin errors++; $display("FAIL mid_out: got v=%b port=%0d want 1,0", out_valid, out_port); end
    tick();
  endtask

  task automatic test_random();
    logic [NPORTS-1:0] expR;
    resetDut();
    for (int c = 0; c < 400; c++) begin
      Enable    = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < NPORTS; p++) begin
        if (!req_valid[p] && $urandom_range(0, 2) == 0)
          setPort(p, 1'b1, ($urandom_range(0, 9) == 0), randLen(), randHdr());
        else if (req_valid[p] && $urandom_range(0, 19) == 0)
          req_valid[p] = 1'b0;
      end
      @(negedge MRxClk);
      expR = mReady();
      checks++; if (req_ready !== expR) begin errors++; $display("FAIL rnd_ready%0d: got %b want %b", c, req_ready, expR); end
      checks++; if (out_valid !== mSend || busy !== mSend)
        begin errors++; $display("FAIL rnd_valid%0d: got v=%b busy=%b want %b", c, out_valid, busy, mSend); end
      checks++; if (drop_cnt !== 16'(mDrop)) begin errors++; $display("FAIL rnd_drop%0d: got %0d want %0d", c, drop_cnt, mDrop); end
      if (mSend) begin
        checks++; if (out_port !== PW'(mPort) || out_len !== mLen || out_data !== mData)
          begin errors++; $display("FAIL rnd_out%0d: got port=%0d len=%0d want port=%0d len=%0d", c, out_port, out_len, mPort, mLen); end
      end
      tick();
      for (int p = 0; p < NPORTS; p++) if (expR[p]) req_valid[p] = 1'b0;
    end
  endtask

  task automatic test_saturation();
    resetDut();
    setPort(0, 1'b1, 1'b1, 16'd64, '0);
    for (int i = 0; i < 65534; i++) tick();
    @(negedge MRxClk);
    checks++; if (drop_cnt !== 16'd65534) begin errors++; $display("FAIL sat_pre: got %0d want 65534", drop_cnt); end
    for (int i = 0; i < 6; i++) tick();
    @(negedge MRxClk);
    checks++; if (drop_cnt !== 16'hFFFF || out_valid !== 1'b0)
      begin errors++; $display("FAIL sat_cnt: got %0d v=%b want 65535,0", drop_cnt, out_valid); end
    req_valid = '0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    Reset = 1'b0;
    clearInputs();
    mReset();
    test_reset();
    test_single();
    test_all_ports();
    test_drops();
    test_stall();
    test_enable();
    test_reset_midsend();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
